// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one word-bus transaction at a time, aligned
// and extended load data or an error pulse back to writeback
module lsu #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_e;

  localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_q, data_d, cnt_q, cnt_d;
  logic [1:0]  size_q;
  logic        write_q, unsigned_q;
  logic        accept, misaligned, timeout_hit;

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] o,
                                          input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = rd >> {o, 3'b000};
    case (sz)
      2'd0:    extract = {{24{~uns & s[7]}}, s[7:0]};
      2'd1:    extract = {{16{~uns & s[15]}}, s[15:0]};
      default: extract = rd;
    endcase
  endfunction

  assign accept     = req_valid && (state_q == S_IDLE);
  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  // Completion in the same cycle always wins over the timeout.
  assign timeout_hit = (TIMEOUT != 32'd0) && ((cnt_q + 32'd1) >= TIMEOUT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (accept) state_d = misaligned ? S_ERR : S_REQ;
      end
      S_REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_ready) begin
          if (write_q) begin
            state_d = S_DONE;
          end else if (mem_rvalid) begin
            data_d  = extract(mem_rdata, addr_q[1:0], size_q, unsigned_q);
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          data_d  = extract(mem_rdata, addr_q[1:0], size_q, unsigned_q);
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      data_q     <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        data_q     <= 32'd0;
      end
    end
  end

  // Bus fields are only driven while a request is on the bus.
  always_comb begin
    mem_valid = (state_q == S_REQ);
    mem_addr  = 32'd0;
    mem_write = 1'b0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'd0;
    if (mem_valid) begin
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_write = write_q;
      if (write_q) begin
        case (size_q)
          2'd0: begin
            mem_wstrb = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'd1: begin
            mem_wstrb = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_wstrb = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_data  = (state_q == S_DONE && !write_q) ? data_q : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu (MEM_TIMEOUT = 4)
module tb_lsu;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_valid, mem_ready, mem_write, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Read with ready and rvalid together in the first REQ cycle.
  task automatic fast_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
    issue(1'b0, sz, uns, a, 32'd0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_data"}, resp_data, exp);
    tick();
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] lane);
    mem_ready = 1'b1;
    issue(1'b1, sz, 1'b0, a, wd);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(strb));
    chk({tag, "_wdata"}, mem_wdata, lane);
    chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
    tick();
    mem_ready = 1'b0;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    tick();
    chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic slow_half(input string tag, input logic uns, input logic [31:0] exp);
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    issue(1'b0, 2'd1, uns, 32'h0000_2002, 32'd0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_wstrb_load"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0000_2000);
    tick();
    mem_ready = 1'b0;
    chk({tag, "_wait_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_wait_resp"}, 32'(resp_valid), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    chk({tag, "_wait2_resp"}, 32'(resp_valid), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_data"}, resp_data, exp);
    tick();
  endtask

  task automatic err_op(input string tag, input logic [1:0] sz, input logic [31:0] a);
    mem_ready = 1'b1;
    issue(1'b0, sz, 1'b0, a, 32'd0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd1);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #2;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    store("sb", 2'd0, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    store("sh", 2'd1, 32'h0000_0002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store("sw", 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    slow_half("lh", 1'b0, 32'hFFFF_8001);
    slow_half("lhu", 1'b1, 32'h0000_8001);

    fast_load("lbu", 2'd0, 1'b1, 32'h0000_6001, 32'h1234_5678, 32'h0000_0056);
    fast_load("lb", 2'd0, 1'b0, 32'h0000_7003, 32'hF000_0000, 32'hFFFF_FFF0);
    fast_load("lw", 2'd2, 1'b0, 32'h0000_7004, 32'h8765_4321, 32'h8765_4321);

    err_op("mis_w", 2'd2, 32'h0000_3001);
    err_op("mis_h", 2'd1, 32'h0000_3005);
    err_op("ill_sz", 2'd3, 32'h0000_4000);

    // Timeout: four REQ cycles with mem_ready low, then error.
    mem_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_mem_valid_%0d", i), 32'(mem_valid), 32'd1);
      chk($sformatf("to_no_resp_%0d", i), 32'(resp_valid), 32'd0);
      tick();
    end
    chk("to_mem_valid_drop", 32'(mem_valid), 32'd0);
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_err", 32'(resp_err), 32'd1);
    chk("to_resp_data", resp_data, 32'd0);
    tick();
    chk("to_req_ready", 32'(req_ready), 32'd1);

    // Reset while waiting for read data; late rvalid must be ignored.
    mem_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("rw_in_wait", 32'(mem_valid), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("rw_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rw_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_rst_mem_addr", mem_addr, 32'd0);
    chk("rw_rst_resp_data", resp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_late_rvalid_resp", 32'(resp_valid), 32'd0);
    chk("rw_idle_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rw_late_rvalid_resp2", 32'(resp_valid), 32'd0);
    fast_load("rw_next", 2'd2, 1'b0, 32'h0000_5000, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
